// File: rtl/data_ram_arbiter.sv
// Two-master data RAM arbiter: pipeline M has priority, DMA D wins after STARVE_LIMIT denied cycles.
// Zero latency (combinational grant); loser held via m_stall / absent d_ack. `DATA_ARB_BURST_EN enables D bursts.
module data_ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [3:0]  m_sel,
    input  logic [31:0] m_data_i,
    output logic [31:0] m_data_o,
    output logic        m_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_sel,
    input  logic [3:0]  d_len,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_q, starve_d;
    logic        in_arb, d_gnt_arb, d_beat, m_gnt;
    logic        beat_we;
    logic [3:0]  beat_sel;
    logic [31:0] beat_addr;

`ifdef DATA_ARB_BURST_EN
    typedef enum logic {ARB, D_BURST} state_t;
    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  beats_q, beats_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            addr_q  <= 32'h0;
            beats_q <= 4'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        in_arb    = (state_q == ARB);
        d_gnt_arb = in_arb && d_req && (!m_req || starve_q == LIMIT);
        d_beat    = d_gnt_arb || (state_q == D_BURST && d_req);
        beat_addr = in_arb ? d_addr : addr_q;
        beat_we   = in_arb ? d_we   : we_q;
        beat_sel  = in_arb ? d_sel  : sel_q;
        case (state_q)
            ARB: begin
                if (d_gnt_arb && d_len != 4'h0) begin
                    we_d    = d_we;
                    sel_d   = d_sel;
                    addr_d  = d_addr + 32'd4;
                    beats_d = d_len;
                    state_d = D_BURST;
                end
            end
            D_BURST: begin
                // Dropping d_req mid-burst aborts; D restarts from ARB.
                if (d_req) begin
                    addr_d  = addr_q + 32'd4;
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) state_d = ARB;
                end else begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end
`else
    logic [3:0] d_len_unused;
    assign d_len_unused = d_len;

    always_comb begin
        in_arb    = 1'b1;
        d_gnt_arb = d_req && (!m_req || starve_q == LIMIT);
        d_beat    = d_gnt_arb;
        beat_addr = d_addr;
        beat_we   = d_we;
        beat_sel  = d_sel;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= 4'h0;
        else      starve_q <= starve_d;
    end

    always_comb begin
        m_gnt    = in_arb && !d_gnt_arb && m_req;
        starve_d = starve_q;
        if (!d_req || d_beat)                   starve_d = 4'h0;
        else if (m_gnt && starve_q != 4'hF)     starve_d = starve_q + 4'd1;
    end

    // Every output is forced low while reset is held, independent of state.
    always_comb begin
        m_data_o   = 32'h0;
        m_stall    = 1'b0;
        d_rdata    = 32'h0;
        d_ack      = 1'b0;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = 32'h0;
        ram_sel    = 4'h0;
        ram_data_o = 32'h0;
        if (rst) begin
            m_stall = m_req && !m_gnt;
            if (m_gnt) begin
                ram_ce     = 1'b1;
                ram_we     = m_we;
                ram_addr   = m_addr;
                ram_sel    = m_sel;
                ram_data_o = m_data_i;
                if (!m_we) m_data_o = ram_data_i;
            end else if (d_beat) begin
                d_ack      = 1'b1;
                ram_ce     = 1'b1;
                ram_we     = beat_we;
                ram_addr   = beat_addr;
                ram_sel    = beat_sel;
                ram_data_o = d_wdata;
                if (!beat_we) d_rdata = ram_data_i;
            end
        end
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural RAM; burst scenarios only when DATA_ARB_BURST_EN is set.
module tb_data_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_req, m_we, d_req, d_we;
    logic [31:0] m_addr, m_data_i, d_addr, d_wdata;
    logic [3:0]  m_sel, d_sel, d_len;
    logic [31:0] m_data_o, d_rdata, ram_addr, ram_data_o, ram_data_i;
    logic        m_stall, d_ack, ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
        .m_data_i(m_data_i), .m_data_o(m_data_o), .m_stall(m_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel),
        .d_len(d_len), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    assign ram_data_i = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
        end
    end

    // Inputs change 1 time unit after posedge; checks run 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req = 0; m_we = 0; m_addr = 0; m_sel = 0; m_data_i = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_sel = 0; d_len = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        m_req = 1; m_we = 0; m_addr = 32'h10; m_sel = 4'hF; m_data_i = 32'h1;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_sel = 4'hF; d_len = 4'h3; d_wdata = 32'h2;
        #4;
        checks++; if (ram_ce !== 1'b0) begin failures++; $display("FAIL reset_ram_ce got=%b exp=0", ram_ce); end
        checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL reset_m_stall got=%b exp=0", m_stall); end
        checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL reset_d_ack got=%b exp=0", d_ack); end
        checks++; if ({ram_we, ram_addr, ram_sel, ram_data_o, m_data_o, d_rdata} !== '0) begin
            failures++; $display("FAIL reset_buses got addr=%h data=%h exp=0", ram_addr, ram_data_o); end
        tick(); tick();
        rst = 1;
        idle_inputs();
    endtask

    task automatic test_idle();
        tick();
        #4;
        checks++; if ({ram_ce, ram_we, ram_addr, ram_sel, ram_data_o, m_stall, d_ack} !== '0) begin
            failures++; $display("FAIL idle_outputs got ce=%b addr=%h exp=0", ram_ce, ram_addr); end
    endtask

    task automatic test_m_write_read();
        tick();
        m_req = 1; m_we = 1; m_addr = 32'h10; m_sel = 4'hF; m_data_i = 32'hDEADBEEF;
        #4;
        checks++; if ({ram_ce, ram_we, m_stall} !== 3'b110) begin
            failures++; $display("FAIL m_write_ctl got ce/we/stall=%b exp=110", {ram_ce, ram_we, m_stall}); end
        checks++; if (ram_addr !== 32'h10 || ram_data_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL m_write_bus got addr=%h data=%h exp=00000010/deadbeef", ram_addr, ram_data_o); end
        tick();
        m_we = 0; m_data_i = 0;
        #4;
        checks++; if (m_data_o !== 32'hDEADBEEF || m_stall !== 1'b0 || ram_ce !== 1'b1) begin
            failures++; $display("FAIL m_read got data=%h stall=%b ce=%b exp=deadbeef/0/1", m_data_o, m_stall, ram_ce); end
        tick();
        m_we = 1; m_sel = 4'b0011; m_data_i = 32'h5555_1234;
        tick();
        m_we = 0; m_sel = 4'hF; m_data_i = 0;
        #4;
        checks++; if (m_data_o !== 32'hDEAD1234) begin
            failures++; $display("FAIL m_partial_write got=%h exp=dead1234", m_data_o); end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [5:0] ack_seen, stall_seen;
        ack_seen = '0; stall_seen = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            m_req = 1; m_we = 0; m_addr = 32'h10; m_sel = 4'hF;
            d_req = 1; d_we = 0; d_addr = 32'h10; d_sel = 4'hF; d_len = 0;
            #4;
            ack_seen[c] = d_ack;
            stall_seen[c] = m_stall;
            if (c == 4) begin
                checks++; if (d_rdata !== 32'hDEAD1234 || m_data_o !== 32'h0) begin
                    failures++; $display("FAIL starve_d_read got d_rdata=%h m_data_o=%h exp=dead1234/0", d_rdata, m_data_o); end
            end
            if (c == 5) begin
                checks++; if (m_data_o !== 32'hDEAD1234) begin
                    failures++; $display("FAIL starve_m_resume got=%h exp=dead1234", m_data_o); end
            end
        end
        checks++; if (ack_seen !== 6'b010000) begin
            failures++; $display("FAIL starve_ack_pattern got=%b exp=010000", ack_seen); end
        checks++; if (stall_seen !== 6'b010000) begin
            failures++; $display("FAIL starve_stall_pattern got=%b exp=010000", stall_seen); end
        tick();
        idle_inputs();
    endtask

`ifndef DATA_ARB_BURST_EN
    task automatic test_single_beat();
        int acks;
        acks = 0;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_sel = 4'hF; d_len = 4'h5; d_wdata = 32'hA5A5_0001;
        #4;
        acks += int'(d_ack);
        checks++; if (ram_addr !== 32'h40 || ram_we !== 1'b1) begin
            failures++; $display("FAIL single_beat_bus got addr=%h we=%b exp=00000040/1", ram_addr, ram_we); end
        tick();
        m_req = 1; m_we = 0; m_addr = 32'h40; m_sel = 4'hF;
        #4;
        acks += int'(d_ack);
        checks++; if (m_stall !== 1'b0 || m_data_o !== 32'hA5A5_0001) begin
            failures++; $display("FAIL single_beat_m_prio got stall=%b data=%h exp=0/a5a50001", m_stall, m_data_o); end
        tick();
        d_req = 0;
        #4;
        acks += int'(d_ack);
        checks++; if (acks !== 1) begin
            failures++; $display("FAIL single_beat_acks got=%0d exp=1", acks); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h44; d_sel = 4'hF; d_wdata = 32'h7;
        rst = 0;
        #4;
        checks++; if ({ram_ce, d_ack, ram_addr, ram_data_o} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs got ce=%b ack=%b exp=0", ram_ce, d_ack); end
        tick();
        rst = 1; idle_inputs();
        tick();
        m_req = 1; m_addr = 32'h40; m_sel = 4'hF;
        #4;
        checks++; if (m_data_o !== 32'hA5A5_0001 || m_stall !== 1'b0) begin
            failures++; $display("FAIL reset_mid_m_read got data=%h stall=%b exp=a5a50001/0", m_data_o, m_stall); end
        tick();
        idle_inputs();
    endtask
`else
    task automatic test_burst_write();
        for (int i = 0; i < 4; i++) begin
            tick();
            m_req = (i > 0); m_we = 0; m_addr = 32'h10; m_sel = 4'hF;
            d_req = 1; d_we = (i == 0); d_addr = (i == 0) ? 32'h100 : 32'h0;
            d_sel = (i == 0) ? 4'hF : 4'h0; d_len = 4'h3; d_wdata = 32'(i + 1);
            #4;
            checks++; if (d_ack !== 1'b1 || ram_addr !== 32'h100 + 32'(4 * i) || ram_we !== 1'b1 || ram_sel !== 4'hF) begin
                failures++; $display("FAIL burst_beat%0d got ack=%b addr=%h we=%b sel=%h", i, d_ack, ram_addr, ram_we, ram_sel); end
            checks++; if (m_stall !== (i > 0)) begin
                failures++; $display("FAIL burst_stall%0d got=%b exp=%b", i, m_stall, i > 0); end
        end
        tick();
        d_req = 0;
        #4;
        checks++; if (m_stall !== 1'b0 || d_ack !== 1'b0) begin
            failures++; $display("FAIL burst_end got stall=%b ack=%b exp=0/0", m_stall, d_ack); end
        checks++; if (mem[64] !== 32'd1 || mem[65] !== 32'd2 || mem[66] !== 32'd3 || mem[67] !== 32'd4) begin
            failures++; $display("FAIL burst_mem got %h %h %h %h exp=1 2 3 4", mem[64], mem[65], mem[66], mem[67]); end
        tick();
        idle_inputs();
    endtask

    task automatic test_burst_abort();
        int acks;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            d_req = (i < 2); d_we = 1; d_addr = 32'h200; d_sel = 4'hF; d_len = 4'h7;
            d_wdata = 32'h11 * (i + 1);
            #4;
            acks += int'(d_ack);
            if (i == 2) begin
                checks++; if (ram_ce !== 1'b0 || d_ack !== 1'b0) begin
                    failures++; $display("FAIL abort_cycle got ce=%b ack=%b exp=0/0", ram_ce, d_ack); end
            end
        end
        checks++; if (acks !== 2) begin
            failures++; $display("FAIL abort_acks got=%0d exp=2", acks); end
        tick();
        idle_inputs();
        m_req = 1; m_addr = 32'h204; m_sel = 4'hF;
        #4;
        checks++; if (m_data_o !== 32'h22 || m_stall !== 1'b0) begin
            failures++; $display("FAIL abort_m_read got data=%h stall=%b exp=00000022/0", m_data_o, m_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin
            tick();
            d_req = 1; d_we = 1; d_addr = 32'h300; d_sel = 4'hF; d_len = 4'h3; d_wdata = 32'h9;
            if (i == 2) rst = 0;
            #4;
        end
        checks++; if ({ram_ce, d_ack, m_stall, ram_addr, ram_data_o} !== '0) begin
            failures++; $display("FAIL reset_mid_outputs got ce=%b ack=%b exp=0", ram_ce, d_ack); end
        tick();
        rst = 1; idle_inputs();
        tick();
        m_req = 1; m_addr = 32'h100; m_sel = 4'hF;
        #4;
        checks++; if (m_data_o !== 32'd1 || m_stall !== 1'b0 || d_ack !== 1'b0) begin
            failures++; $display("FAIL reset_mid_m_read got data=%h stall=%b exp=1/0", m_data_o, m_stall); end
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_idle();
        test_m_write_read();
        test_starvation();
`ifndef DATA_ARB_BURST_EN
        test_single_beat();
        test_reset_mid_access();
`else
        test_burst_write();
        test_burst_abort();
        test_reset_mid_burst();
`endif
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-master arbiter in front of the data RAM. It shares the single data RAM port between the pipeline MEM stage (master M) and a DMA/loader engine (master D). M has default priority; D can preempt after a bounded wait, and can own the RAM for multi-beat bursts. M is stalled through the pipeline control stall chain whenever it loses the port.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles after which D beats M. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- m_req  in  1  M access request, valid this cycle.
- m_we  in  1  M write enable.
- m_addr  in  32  M byte address.
- m_sel  in  4  M byte lane select.
- m_data_i  in  32  M write data.
- m_data_o  out  32  M read data.
- m_stall  out  1  M denied this cycle; hold request.
- d_req  in  1  D access request.
- d_we  in  1  D write enable; sampled at burst start.
- d_addr  in  32  D start byte address.
- d_sel  in  4  D lane select; sampled at burst start.
- d_len  in  4  D burst beats minus 1.
- d_wdata  in  32  D write data, current beat.
- d_rdata  out  32  D read data, current beat.
- d_ack  out  1  D beat performed this cycle.
- ram_ce, ram_we  out  1 each  RAM chip enable and write enable.
- ram_addr  out  32  RAM address.
- ram_sel  out  4  RAM lane select.
- ram_data_o  out  32  write data to RAM.
- ram_data_i  in  32  read data from RAM (combinational).

## Operation
- FSM states:
  - ARB: per-cycle arbitration.
  - D_BURST: D owns the RAM.
- ARB winner:
  - D wins if d_req and (!m_req or starve_cnt==STARVE_LIMIT).
  - Otherwise M wins if m_req.
  - Otherwise idle.
- starve_cnt (4-bit, saturating):
  - +1 when in ARB with d_req and M granted.
  - Cleared on D grant or when d_req=0.
- D granted in ARB:
  - Beat 0 uses d_addr, d_we, d_sel, d_wdata; d_ack=1.
  - If d_len!=0: latch we and sel, set burst_addr=d_addr+4, beats_left=d_len, go to D_BURST.
- D_BURST, per cycle with d_req=1:
  - RAM driven from burst_addr, latched we and sel, and live d_wdata; d_ack=1.
  - burst_addr+=4, wrapping mod 2^32.
  - beats_left-=1; on the beat where beats_left==1, return to ARB.
- D_BURST with d_req=0: abort. No RAM access and d_ack=0 this cycle; go to ARB.
- While D is granted (ARB or D_BURST): m_stall=m_req.
- Read data:
  - m_data_o=ram_data_i when M is granted and !m_we, else 0.
  - d_rdata=ram_data_i when d_ack and !we, else 0.
- Idle cycle: ram_ce=0; ram_we, ram_addr, ram_sel, ram_data_o all 0.
- While rst=0:
  - State forced to ARB; starve_cnt, beats_left, burst_addr forced to 0.
  - All outputs 0, including m_stall and d_ack.
- Reset asserted mid-burst: burst dropped immediately. D must reissue after reset.

## Timing
- Outputs are combinational from the current state and inputs.
- Uncontested M has zero added latency:
  - Read data valid in the same cycle.
  - Write committed at the posedge ending the grant cycle.
- D burst of N=d_len+1 beats with d_req held:
  - Occupies exactly N consecutive cycles.
  - M is stalled for all N cycles if requesting.
- Contention:
  - D waits at most STARVE_LIMIT cycles of M traffic, then is granted on the next cycle.
  - The M request in that cycle sees m_stall=1.
- After a burst ends, the ARB cycle applies normal M priority. starve_cnt starts from 0.

## Configuration
- DATA_ARB_BURST_EN defined: burst behaviour as above.
- Not defined:
  - d_len is ignored; no D_BURST state or burst registers exist.
  - Every D grant is a single beat and the FSM stays in ARB.

## Test plan
- M reads only, contention-free: preload addr 0x10=0xDEADBEEF, m_req read 0x10 -> same cycle m_data_o=0xDEADBEEF, m_stall=0, ram_ce=1.
- Starvation, STARVE_LIMIT=4: m_req and d_req held high continuously from cycle 0 -> M granted cycles 0-3; cycle 4 d_ack=1 and m_stall=1; cycle 5 M granted again.
- Burst write: d_addr=0x100, d_len=3, d_we=1, sel=0xF, data 1,2,3,4 -> writes to 0x100,0x104,0x108,0x10C in 4 cycles; concurrent m_req sees m_stall=1 for all 4.
- Burst abort: d_len=7, drop d_req after 2 acks -> third cycle ram_ce=0 (or M granted), d_ack=0; only 2 words written.
- Reset mid-burst: assert rst=0 during beat 2 of a 4-beat burst -> all outputs 0 immediately; after release, FSM in ARB and a single M read succeeds.
- Macro off: d_len=5 -> exactly one d_ack, then M regains priority next cycle.
